// File: rtl/column_bank_scheduler_if.sv
// Avalon-MM slave bus carrying host column records and control/status
// traffic into column_bank_scheduler.
interface column_bank_scheduler_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [1:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/column_bank_scheduler.sv
// column_bank_scheduler: assembles 4-word column records from the host bus,
// commits them into the current write bank and rotates three column banks
// (write / pending / read) so the display always shows the newest complete
// frame. The read bank only changes on the VGA frame-boundary pulse.
// Optional feature: define FRAME_IRQ_EN for a sticky frame-swap interrupt.
module column_bank_scheduler #(
    parameter int NCOLS = 640,
    parameter int COLW  = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    column_bank_scheduler_if.slave bus,
    input  logic                 frame_boundary,
    output logic [2:0]           bank_we,
    output logic [COLW-1:0]      bank_wcol,
    output logic [41:0]          bank_wdata,
    output logic [15:0]          bank_wsf,
    output logic [1:0]           rd_bank,
    output logic [1:0]           wr_bank,
    output logic                 frame_pending,
    output logic                 irq
);

    localparam logic [COLW-1:0] LAST_COL = COLW'(NCOLS - 1);

    logic [1:0]      stage;
    logic [COLW-1:0] col_ptr;
    logic [1:0]      pending_bank;
    logic [15:0]     drop_cnt;
    logic [9:0]      word0;
    logic [15:0]     word1, word2;

    logic            data_wr, ctrl_wr, commit, frame_done;
    logic [1:0]      rd_nxt, wr_nxt, pend_nxt;
    logic            fp_nxt, drop_inc;
    logic [9:0]      col_status;

    assign data_wr    = bus.chipselect & bus.write & (bus.address == 2'd0);
    assign ctrl_wr    = bus.chipselect & bus.write & (bus.address == 2'd1);
    assign commit     = data_wr & (stage == 2'd3);
    assign frame_done = commit & (col_ptr == LAST_COL);
    assign col_status = 10'(col_ptr);

    // Bank rotation: a completed frame and a frame boundary are resolved
    // together so the three bank indices always stay a permutation of 0..2.
    always_comb begin
        rd_nxt   = rd_bank;
        wr_nxt   = wr_bank;
        pend_nxt = pending_bank;
        fp_nxt   = frame_pending;
        drop_inc = 1'b0;
        if (frame_done && frame_boundary) begin
            // Fresh frame goes straight to display; any pending frame is stale.
            rd_nxt   = wr_bank;
            wr_nxt   = rd_bank;
            fp_nxt   = 1'b0;
            drop_inc = frame_pending;
        end else if (frame_done) begin
            if (!frame_pending) begin
                pend_nxt = wr_bank;
                wr_nxt   = 2'd3 ^ wr_bank ^ rd_bank;
                fp_nxt   = 1'b1;
            end else begin
                // Newest frame replaces the undisplayed one.
                pend_nxt = wr_bank;
                wr_nxt   = pending_bank;
                drop_inc = 1'b1;
            end
        end else if (frame_boundary && frame_pending) begin
            rd_nxt   = pending_bank;
            pend_nxt = rd_bank;
            fp_nxt   = 1'b0;
        end
    end

    // Record assembly, column pointer, bank state and drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage         <= 2'd0;
            col_ptr       <= '0;
            word0         <= '0;
            word1         <= '0;
            word2         <= '0;
            rd_bank       <= 2'd0;
            wr_bank       <= 2'd1;
            pending_bank  <= 2'd2;
            frame_pending <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            if (data_wr) begin
                stage <= stage + 2'd1;
                case (stage)
                    2'd0:    word0 <= bus.writedata[9:0];
                    2'd1:    word1 <= bus.writedata;
                    2'd2:    word2 <= bus.writedata;
                    default: col_ptr <= (col_ptr == LAST_COL) ? '0 : col_ptr + 1'b1;
                endcase
            end else if (ctrl_wr && bus.writedata[0]) begin
                stage   <= 2'd0;
                col_ptr <= '0;
            end
            rd_bank       <= rd_nxt;
            wr_bank       <= wr_nxt;
            pending_bank  <= pend_nxt;
            frame_pending <= fp_nxt;
            if (drop_inc && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Bank write port: one-cycle pulse into the pre-swap write bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_we    <= '0;
            bank_wcol  <= '0;
            bank_wdata <= '0;
            bank_wsf   <= '0;
        end else begin
            bank_we <= commit ? (3'b001 << wr_bank) : 3'b000;
            if (commit) begin
                bank_wcol  <= col_ptr;
                bank_wdata <= {word2, word1, word0};
                bank_wsf   <= bus.writedata;
            end
        end
    end

`ifdef FRAME_IRQ_EN
    // Sticky swap interrupt; a swap in the same cycle beats the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else if (rd_nxt != rd_bank)
            irq <= 1'b1;
        else if (ctrl_wr && bus.writedata[1])
            irq <= 1'b0;
    end
`else
    assign irq = 1'b0;
`endif

    // Registered read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.readdata <= '0;
        else if (bus.chipselect && bus.read) begin
            case (bus.address)
                2'd0:    bus.readdata <= {irq, frame_pending, rd_bank, stage, col_status};
                2'd1:    bus.readdata <= drop_cnt;
                default: bus.readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_column_bank_scheduler.sv
// Directed bench for column_bank_scheduler: record commit, frame rotation,
// dropped frames, commit/boundary coincidence, resync and the swap interrupt.
module tb_column_bank_scheduler;

    localparam int NCOLS = 640;
    localparam int COLW  = 10;
`ifdef FRAME_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            frame_boundary = 1'b0;
    logic [2:0]      bank_we;
    logic [COLW-1:0] bank_wcol;
    logic [41:0]     bank_wdata;
    logic [15:0]     bank_wsf;
    logic [1:0]      rd_bank, wr_bank;
    logic            frame_pending, irq;

    int checks = 0;
    int errors = 0;

    column_bank_scheduler_if bus ();

    column_bank_scheduler #(.NCOLS(NCOLS), .COLW(COLW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus.slave),
        .frame_boundary (frame_boundary),
        .bank_we        (bank_we),
        .bank_wcol      (bank_wcol),
        .bank_wdata     (bank_wdata),
        .bank_wsf       (bank_wsf),
        .rd_bank        (rd_bank),
        .wr_bank        (wr_bank),
        .frame_pending  (frame_pending),
        .irq            (irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic pulse_fb();
        frame_boundary = 1'b1;
        @(negedge clk);
        frame_boundary = 1'b0;
    endtask

    task automatic record(input logic [15:0] base, input logic fb_last);
        bus_wr(2'd0, base);
        bus_wr(2'd0, base + 16'd1);
        bus_wr(2'd0, base + 16'd2);
        frame_boundary = fb_last;
        bus_wr(2'd0, base + 16'd3);
        frame_boundary = 1'b0;
    endtask

    task automatic frame(input logic fb_last);
        for (int i = 0; i < NCOLS; i++)
            record(16'(i), fb_last && (i == NCOLS - 1));
    endtask

    task automatic do_reset();
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = 2'd0; bus.writedata = 16'd0; frame_boundary = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    logic [15:0] rdata;

    initial begin
        // ---- reset state
        do_reset();
        check("rst_rd_bank", rd_bank, 2'd0);
        check("rst_wr_bank", wr_bank, 2'd1);
        check("rst_pending", frame_pending, 1'b0);
        check("rst_bank_we", bank_we, 3'b000);
        check("rst_irq", irq, 1'b0);
        bus_rd(2'd0, rdata);
        check("rst_status", rdata, 16'h0000);
        bus_rd(2'd1, rdata);
        check("rst_drop", rdata, 16'h0000);

        // ---- single record commit
        bus_wr(2'd0, 16'h0123);
        bus_wr(2'd0, 16'hAAAA);
        bus_wr(2'd0, 16'h5555);
        bus_wr(2'd0, 16'h0040);
        check("rec_we", bank_we, 3'b010);
        check("rec_wcol", bank_wcol, 10'd0);
        check("rec_wdata", bank_wdata, {16'h5555, 16'hAAAA, 10'h123});
        check("rec_wsf", bank_wsf, 16'h0040);
        @(negedge clk);
        check("rec_we_pulse", bank_we, 3'b000);
        bus_rd(2'd0, rdata);
        check("rec_status", rdata, 16'h0001);

        // ---- full frame then boundary
        do_reset();
        frame(1'b0);
        check("f1_last_we", bank_we, 3'b010);
        check("f1_last_wcol", bank_wcol, 10'd639);
        check("f1_pending", frame_pending, 1'b1);
        check("f1_wr_bank", wr_bank, 2'd2);
        check("f1_rd_bank", rd_bank, 2'd0);
        pulse_fb();
        check("fb_rd_bank", rd_bank, 2'd1);
        check("fb_pending", frame_pending, 1'b0);
        check("fb_wr_bank", wr_bank, 2'd2);
        check("fb_irq", irq, IRQ_EN);
        bus_rd(2'd0, rdata);
        check("fb_status", rdata, {IRQ_EN, 1'b0, 2'd1, 2'd0, 10'd0});
        bus_wr(2'd1, 16'h0002);
        check("irq_clear", irq, 1'b0);
        // frame lands in bank 2 -> pending; swap coincides with irq clear
        frame(1'b0);
        check("f2_pending", frame_pending, 1'b1);
        check("f2_wr_bank", wr_bank, 2'd0);
        frame_boundary = 1'b1;
        bus_wr(2'd1, 16'h0002);
        frame_boundary = 1'b0;
        check("swap_rd_bank", rd_bank, 2'd2);
        check("irq_set_wins", irq, IRQ_EN);

        // ---- two frames without boundary: second replaces first
        do_reset();
        frame(1'b0);
        frame(1'b0);
        check("dd_pending", frame_pending, 1'b1);
        check("dd_wr_bank", wr_bank, 2'd1);
        bus_rd(2'd1, rdata);
        check("dd_drop", rdata, 16'd1);
        pulse_fb();
        check("dd_rd_bank", rd_bank, 2'd2);
        check("dd_rd_ne_wr", rd_bank != wr_bank, 1'b1);
        check("dd_pending_clr", frame_pending, 1'b0);

        // ---- last commit coincident with boundary, nothing pending
        do_reset();
        frame(1'b1);
        check("co_rd_bank", rd_bank, 2'd1);
        check("co_wr_bank", wr_bank, 2'd0);
        check("co_pending", frame_pending, 1'b0);
        bus_rd(2'd1, rdata);
        check("co_drop", rdata, 16'd0);

        // ---- resync mid-record
        do_reset();
        bus_wr(2'd0, 16'h0111);
        bus_wr(2'd0, 16'h0222);
        bus_rd(2'd0, rdata);
        check("rs_stage2", rdata, 16'h0800);
        bus_wr(2'd1, 16'h0001);
        bus_rd(2'd0, rdata);
        check("rs_status", rdata, 16'h0000);
        bus_wr(2'd0, 16'h0155);
        bus_wr(2'd0, 16'h1111);
        bus_wr(2'd0, 16'h2222);
        bus_wr(2'd0, 16'h3333);
        check("rs_we", bank_we, 3'b010);
        check("rs_wcol", bank_wcol, 10'd0);
        check("rs_wdata", bank_wdata, {16'h2222, 16'h1111, 10'h155});
        check("rs_wsf", bank_wsf, 16'h3333);
        bus_rd(2'd2, rdata);
        check("rsvd_read", rdata, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
